fifo_stim_driver: RTL
=====================

# fifo_stim_driver

Synthesizable write-side stimulus sequencer for the FIFO/LIFO test environment. It generates a programmed burst of data words (incrementing, decrementing, LFSR or constant) and pushes them into a FIFO or LIFO write port under full-flag back-pressure, with optional idle gaps between writes. It sits in front of the device under test as the producer end of the write interface. The value checkers watch the DUT outputs; this block produces the traffic they check.

## Interface
- DATA_W, 8, width of generated write data (mode 2 requires DATA_W = 8)
- CNT_W, 8, width of the burst length and sent counter
- GAP_W, 4, width of the inter-write gap setting
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a burst; sampled only in IDLE
- mode  in  2  data pattern: 0 increment, 1 decrement, 2 LFSR, 3 constant
- seed  in  DATA_W  first data word, latched on start
- count  in  CNT_W  number of writes in the burst, latched on start
- gap  in  GAP_W  idle cycles inserted after each accepted write, latched on start
- full  in  1  DUT full flag; a write is never issued while high
- wr_en  out  1  write strobe to DUT (combinational: state==PUSH && !full)
- wr_data  out  DATA_W  write data, registered
- busy  out  1  high in PUSH, GAP and DONE
- done  out  1  one-cycle pulse at end of burst
- sent_cnt  out  CNT_W  writes accepted in current/last burst

## Operation
- FSM states: IDLE, PUSH, GAP, DONE.
- IDLE: when start=1, latch mode, gap, and count. Load wr_data with seed (mode 2: a seed of 0 is replaced by 1). Clear sent_cnt. If count!=0, go to PUSH; if count==0, go to DONE with no writes.
- PUSH: wr_en = !full. On an accepted write (wr_en=1), increment sent_cnt and advance wr_data. Then:
  - if sent_cnt == count-1, go to DONE;
  - else if gap != 0, load the gap counter with gap and go to GAP;
  - else stay in PUSH.
- While full=1 in PUSH: hold state, wr_data and sent_cnt.
- GAP: wr_en = 0. Decrement the gap counter and return to PUSH when it reaches 1, giving exactly `gap` idle cycles.
- DONE: done = 1 for exactly one cycle, then go to IDLE. wr_data and sent_cnt keep their final values.
- Data advance rules:
  - mode 0: wr_data + 1, modulo 2^DATA_W (0xFF wraps to 0x00).
  - mode 1: wr_data - 1, modulo 2^DATA_W (0x00 wraps to 0xFF).
  - mode 2: Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1. Next = {d[6:0], d7^d5^d4^d3}.
  - mode 3: unchanged.
- start is ignored outside IDLE. Changes to seed, count, gap or mode during a burst have no effect.
- The sent_cnt comparison is unsigned. count = 2^CNT_W - 1 is the largest burst.

## Timing
- Reset values: wr_en 0, wr_data 0, busy 0, done 0, sent_cnt 0; state IDLE; gap counter 0.
- Reset mid-burst: state is IDLE on the next cycle and wr_en drops with it. No write is issued in the cycle after rst is sampled.
- start sampled at edge N: PUSH from N+1, wr_data = seed valid at N+1, first wr_en possible at N+1.
- With gap = 0 and full = 0, writes are back-to-back: one per cycle. A burst of k writes spans cycles N+1..N+k, with done high at N+k+1.
- With gap = g and full = 0, accepted writes are spaced g+1 cycles apart. No gap follows the last write.
- full is sampled combinationally in the same cycle. A write is accepted exactly when wr_en=1 at a rising edge.
- count = 0: done pulses at N+1, wr_en is never asserted, and busy is high only in that cycle.
- start may be asserted in the same cycle done is high. It is ignored, because the block is not yet in IDLE; the earliest restart is the following cycle.

## Test plan
- Increment burst: rst, then start with mode 0, seed 0xFE, count 4, gap 0, full 0. Required: wr_en high for 4 consecutive cycles with wr_data 0xFE, 0xFF, 0x00, 0x01; done pulses once on the next cycle; sent_cnt = 4.
- Back-pressure: mode 1, seed 0x05, count 3; hold full=1 for the first 3 cycles of PUSH. Required: wr_en stays 0 while full is high; wr_data holds 0x05; the writes then emit 0x05, 0x04, 0x03; sent_cnt = 3.
- LFSR pattern with gaps: mode 2, seed 0x00, count 5, gap 2. Required: data sequence 0x01, 0x02, 0x04, 0x08, 0x11; exactly 2 idle cycles between writes; done follows the 5th write by one cycle.
- Zero-length burst: count 0, start pulse. Required: done pulse at N+1, wr_en never high, sent_cnt = 0.
- Reset mid-burst: mode 3, seed 0x5A, count 10, gap 0; assert rst after 3 writes. Required: no write in the cycle after rst is sampled; all outputs return to reset values; a later start with count 2 produces exactly 2 writes.
- Start while busy: pulse start again during PUSH and in the DONE cycle with different seed and count. Required: the burst is unaffected (original seed, original count), and no second burst begins.

Source files
------------

// File: rtl/fifo_stim_driver.sv
// Write-side traffic generator: pushes a programmed burst of patterned data
// words into a FIFO/LIFO write port, honouring the full flag and optional
// idle gaps between accepted writes.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; burst parameters latched on start
// PUSH   | offering a write every cycle full is low
// GAP    | idle cycles after an accepted write (gap_cnt counts down)
// DONE   | one-cycle end-of-burst pulse, then back to IDLE
module fifo_stim_driver #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int GAP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [CNT_W-1:0]  count,
    input  logic [GAP_W-1:0]  gap,
    input  logic              full,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUSH = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_INC  = 2'd0;
    localparam logic [1:0] MODE_DEC  = 2'd1;
    localparam logic [1:0] MODE_LFSR = 2'd2;

    state_t             state, state_nx;
    logic [1:0]         mode_q, mode_nx;
    logic [CNT_W-1:0]   count_q, count_nx;
    logic [GAP_W-1:0]   gap_q, gap_nx;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nx;
    logic [DATA_W-1:0]  wr_data_nx;
    logic [CNT_W-1:0]   sent_cnt_nx;

    // Pattern step; the LFSR taps assume an 8-bit data path
    // (x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0).
    function automatic logic [DATA_W-1:0] next_data(input logic [1:0]        m,
                                                    input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        case (m)
            MODE_INC:  r = d + DATA_W'(1);
            MODE_DEC:  r = d - DATA_W'(1);
            MODE_LFSR: r = {d[DATA_W-2:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
            default:   r = d;
        endcase
        return r;
    endfunction

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mode_q   <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            wr_data  <= '0;
            sent_cnt <= '0;
        end else begin
            state    <= state_nx;
            mode_q   <= mode_nx;
            count_q  <= count_nx;
            gap_q    <= gap_nx;
            gap_cnt  <= gap_cnt_nx;
            wr_data  <= wr_data_nx;
            sent_cnt <= sent_cnt_nx;
        end
    end

    // Next-state, datapath update and write strobe.
    always_comb begin
        state_nx    = state;
        mode_nx     = mode_q;
        count_nx    = count_q;
        gap_nx      = gap_q;
        gap_cnt_nx  = gap_cnt;
        wr_data_nx  = wr_data;
        sent_cnt_nx = sent_cnt;
        wr_en       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    mode_nx     = mode;
                    count_nx    = count;
                    gap_nx      = gap;
                    sent_cnt_nx = '0;
                    // an all-zero LFSR state would lock up
                    if (mode == MODE_LFSR && seed == '0)
                        wr_data_nx = DATA_W'(1);
                    else
                        wr_data_nx = seed;
                    state_nx = (count == '0) ? S_DONE : S_PUSH;
                end
            end

            S_PUSH: begin
                if (!full) begin
                    wr_en       = 1'b1;
                    sent_cnt_nx = sent_cnt + CNT_W'(1);
                    wr_data_nx  = next_data(mode_q, wr_data);
                    if (sent_cnt == count_q - CNT_W'(1)) begin
                        state_nx = S_DONE;
                    end else if (gap_q != '0) begin
                        gap_cnt_nx = gap_q;
                        state_nx   = S_GAP;
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt <= GAP_W'(1)) begin
                    gap_cnt_nx = '0;
                    state_nx   = S_PUSH;
                end else begin
                    gap_cnt_nx = gap_cnt - GAP_W'(1);
                end
            end

            S_DONE: begin
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
